// File: rtl/eth_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_tx_framer: byte-wide Ethernet TX framer (preamble/SFD, pad, FCS, IFG).  |
// | Optional FCS insertion compiled in with macro ETH_TX_FCS_EN.                |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module eth_tx_framer #(
    parameter int IFG_BYTES   = 12,
    parameter int MIN_PAYLOAD = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic [7:0] s_tdata,
    input  logic       s_tlast,
    output logic       tvalid,
    output logic [7:0] tdata,
    output logic       underrun
);

    localparam logic [15:0] c_MIN_LEN  = 16'(MIN_PAYLOAD);
    localparam logic [7:0]  c_IFG_LAST = 8'(IFG_BYTES);
    localparam logic [7:0]  c_PREAMBLE = 8'h55;
    localparam logic [7:0]  c_SFD      = 8'hD5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_PAD  = 3'd3,
`ifdef ETH_TX_FCS_EN
        S_FCS  = 3'd4,
`endif
        S_IFG  = 3'd5
    } state_t;

`ifdef ETH_TX_FCS_EN
    localparam state_t c_AFTER_BODY = S_FCS;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] r;
        r = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    logic [31:0] crc_q, crc_d;
    logic [1:0]  fcs_idx_q, fcs_idx_d;
    logic [31:0] w_fcs;
    assign w_fcs = ~crc_q;
`else
    localparam state_t c_AFTER_BODY = S_IFG;
`endif

    state_t      state_q, state_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic [7:0]  ifg_cnt_q, ifg_cnt_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic        tvalid_q, tvalid_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        underrun_q, underrun_d;
    logic [15:0] w_byte_cnt_inc;

    assign w_byte_cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;

    // Output registers are loaded one cycle ahead of the state that owns them,
    // so the first 0x55 is produced by the IDLE/IFG cycle that launches a frame.
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        ifg_cnt_d  = ifg_cnt_q;
        byte_cnt_d = byte_cnt_q;
        tvalid_d   = 1'b0;
        tdata_d    = 8'h00;
        underrun_d = 1'b0;
`ifdef ETH_TX_FCS_EN
        crc_d      = crc_q;
        fcs_idx_d  = fcs_idx_q;
`endif
        case (state_q)
            S_IDLE, S_IFG: begin
                if (state_q == S_IFG && ifg_cnt_q != c_IFG_LAST) begin
                    ifg_cnt_d = ifg_cnt_q + 8'd1;
                end else if (s_tvalid) begin
                    state_d    = S_PRE;
                    tvalid_d   = 1'b1;
                    tdata_d    = c_PREAMBLE;
                    pre_cnt_d  = 3'd0;
                    byte_cnt_d = 16'd0;
`ifdef ETH_TX_FCS_EN
                    crc_d      = 32'hFFFFFFFF;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                tvalid_d  = 1'b1;
                pre_cnt_d = pre_cnt_q + 3'd1;
                if (pre_cnt_q == 3'd6) begin
                    tdata_d = c_SFD;
                    state_d = S_DATA;
                end else begin
                    tdata_d = c_PREAMBLE;
                end
            end
            S_DATA: begin
                if (s_tvalid) begin
                    tvalid_d   = 1'b1;
                    tdata_d    = s_tdata;
                    byte_cnt_d = w_byte_cnt_inc;
`ifdef ETH_TX_FCS_EN
                    crc_d      = crc_byte(crc_q, s_tdata);
                    fcs_idx_d  = 2'd0;
`endif
                    if (s_tlast) begin
                        ifg_cnt_d = 8'd0;
                        state_d   = (w_byte_cnt_inc < c_MIN_LEN) ? S_PAD : c_AFTER_BODY;
                    end
                end else begin
                    // Underrun: tvalid already low next cycle, so IFG starts one count in
                    underrun_d = 1'b1;
                    ifg_cnt_d  = 8'd1;
                    state_d    = S_IFG;
                end
            end
            S_PAD: begin
                tvalid_d   = 1'b1;
                byte_cnt_d = w_byte_cnt_inc;
`ifdef ETH_TX_FCS_EN
                crc_d      = crc_byte(crc_q, 8'h00);
                fcs_idx_d  = 2'd0;
`endif
                if (w_byte_cnt_inc >= c_MIN_LEN) begin
                    ifg_cnt_d = 8'd0;
                    state_d   = c_AFTER_BODY;
                end
            end
`ifdef ETH_TX_FCS_EN
            S_FCS: begin
                tvalid_d  = 1'b1;
                tdata_d   = w_fcs[{fcs_idx_q, 3'b000} +: 8];
                fcs_idx_d = fcs_idx_q + 2'd1;
                if (fcs_idx_q == 2'd3) begin
                    ifg_cnt_d = 8'd0;
                    state_d   = S_IFG;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pre_cnt_q  <= 3'd0;
            ifg_cnt_q  <= 8'd0;
            byte_cnt_q <= 16'd0;
            tvalid_q   <= 1'b0;
            tdata_q    <= 8'h00;
            underrun_q <= 1'b0;
`ifdef ETH_TX_FCS_EN
            crc_q      <= 32'hFFFFFFFF;
            fcs_idx_q  <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            ifg_cnt_q  <= ifg_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            underrun_q <= underrun_d;
`ifdef ETH_TX_FCS_EN
            crc_q      <= crc_d;
            fcs_idx_q  <= fcs_idx_d;
`endif
        end
    end

    assign s_tready = (state_q == S_DATA);
    assign tvalid   = tvalid_q;
    assign tdata    = tdata_q;
    assign underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_eth_tx_framer: directed self-checking bench for eth_tx_framer.           |
// | Expected frame layout follows ETH_TX_FCS_EN the same way as the design.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_eth_tx_framer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       s_tvalid;
    logic [7:0] s_tdata;
    logic       s_tlast;
    logic       a_tready, a_tvalid, a_und;
    logic [7:0] a_tdata;
    logic       b_tready, b_tvalid, b_und;
    logic [7:0] b_tdata;
    logic       m_tready, m_tvalid, m_und;
    logic [7:0] m_tdata;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int und_n  = 0;
    int und_cyc = 0;
    logic [7:0] cap_d[$];
    int         cap_c[$];

    always #4 clk = ~clk;

    // Instance A: padding disabled (CRC reference case); instance B: defaults.
    eth_tx_framer #(.IFG_BYTES(12), .MIN_PAYLOAD(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid & ~sel), .s_tready(a_tready),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .tvalid(a_tvalid), .tdata(a_tdata),
        .underrun(a_und)
    );

    eth_tx_framer u_dut_b (
        .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid & sel), .s_tready(b_tready),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .tvalid(b_tvalid), .tdata(b_tdata),
        .underrun(b_und)
    );

    assign m_tready = sel ? b_tready : a_tready;
    assign m_tvalid = sel ? b_tvalid : a_tvalid;
    assign m_tdata  = sel ? b_tdata  : a_tdata;
    assign m_und    = sel ? b_und    : a_und;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_tvalid) begin
                cap_d.push_back(m_tdata);
                cap_c.push_back(cyc);
            end
            if (m_und) begin
                und_n++;
                und_cyc = cyc;
            end
        end
    end

    function automatic logic [31:0] ref_crc(input logic [7:0] d[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ d[i][j];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    function automatic int flen(input int p, input int min_len);
        int n;
        n = (p < min_len) ? min_len : p;
`ifdef ETH_TX_FCS_EN
        return 12 + n;
`else
        return 8 + n;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic drive(input logic [7:0] p[$], input int stop_at, input bit hold);
        int idx;
        int guard;
        bit hs;
        idx   = 0;
        guard = 0;
        s_tvalid = 1'b1;
        s_tdata  = p[0];
        s_tlast  = (p.size() == 1);
        while (idx < stop_at && guard < 3000) begin
            @(negedge clk);
            hs = m_tready;
            @(posedge clk);
            #1;
            guard++;
            if (hs) begin
                idx++;
                if (idx < p.size()) begin
                    s_tdata = p[idx];
                    s_tlast = (idx == p.size() - 1);
                end
            end
        end
        s_tvalid = hold;
        s_tlast  = 1'b0;
        check("drive_handshakes", idx, stop_at);
    endtask

    task automatic chk_frame(input int base, input logic [7:0] p[$], input int min_len, input string tag);
        logic [7:0]  e[$];
        logic [7:0]  body[$];
        logic [31:0] f;
        body = p;
        while (body.size() < min_len) body.push_back(8'h00);
        for (int i = 0; i < 7; i++) e.push_back(8'h55);
        e.push_back(8'hD5);
        foreach (body[i]) e.push_back(body[i]);
`ifdef ETH_TX_FCS_EN
        f = ref_crc(body);
        for (int i = 0; i < 4; i++) e.push_back(f[8*i +: 8]);
`endif
        n_cmp++;
        assert (cap_d.size() >= base + e.size()) else begin
            n_fail++;
            $error("FAIL %s_len: observed %0d expected >= %0d", tag, cap_d.size(), base + e.size());
        end
        if (cap_d.size() >= base + e.size()) begin
            for (int i = 0; i < e.size(); i++) begin
                n_cmp++;
                assert (cap_d[base+i] === e[i]) else begin
                    n_fail++;
                    $error("FAIL %s_byte%0d: observed 0x%02h expected 0x%02h", tag, i, cap_d[base+i], e[i]);
                end
            end
            check({tag, "_gapless"}, cap_c[base+e.size()-1] - cap_c[base], e.size() - 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p[$];
        logic [7:0] p2[$];
        int base;
        int u0;
        int len;

        // Reset held with s_tvalid high: everything quiet.
        sel = 1'b0; rst_n = 1'b0; s_tvalid = 1'b1; s_tdata = 8'h00; s_tlast = 1'b0;
        for (int i = 0; i < 9; i++) p.push_back(8'(8'h31 + i));
        repeat (3) @(negedge clk);
        check("rst_a_tvalid", a_tvalid, 0);
        check("rst_a_tdata",  a_tdata,  0);
        check("rst_a_tready", a_tready, 0);
        check("rst_b_tvalid", b_tvalid, 0);
        check("rst_b_tdata",  b_tdata,  0);
        check("rst_b_tready", b_tready, 0);

        // "123456789", no padding; preamble starts straight out of reset.
        base = cap_d.size();
        rst_n = 1'b1;
        s_tdata = p[0];
        @(posedge clk); #1;
        check("first_pre_tvalid", a_tvalid, 1);
        check("first_pre_tdata",  a_tdata,  8'h55);
        check("first_pre_tready", a_tready, 0);
        drive(p, 9, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("crc_len", cap_d.size() - base, flen(9, 0));
        chk_frame(base, p, 0, "crc");
`ifdef ETH_TX_FCS_EN
        check("crc_fcs_const", {cap_d[base+20], cap_d[base+19], cap_d[base+18], cap_d[base+17]}, 32'hCBF43926);
`else
        check("crc_last_is_9", cap_d[base+16], 8'h39);
`endif
        check("crc_no_underrun", und_n, 0);

        // 14-byte payload padded to 60.
        sel = 1'b1;
        base = cap_d.size();
        p = {};
        for (int i = 0; i < 14; i++) p.push_back(8'(i * 17 + 5));
        drive(p, 14, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        check("pad_len", cap_d.size() - base, flen(14, 60));
        chk_frame(base, p, 60, "pad");

        // Single-byte payload.
        base = cap_d.size();
        p = {};
        p.push_back(8'hAB);
        drive(p, 1, 1'b0);
        repeat (90) @(posedge clk);
        #1;
        check("one_len", cap_d.size() - base, flen(1, 60));
        chk_frame(base, p, 60, "one");

        // Back-to-back 64-byte frames with s_tvalid held high.
        base = cap_d.size();
        p = {};
        p2 = {};
        for (int i = 0; i < 64; i++) begin
            p.push_back(8'(i));
            p2.push_back(8'(255 - i));
        end
        drive(p, 64, 1'b1);
        drive(p2, 64, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        len = flen(64, 60);
        check("b2b_len", cap_d.size() - base, 2 * len);
        chk_frame(base, p, 60, "b2b1");
        chk_frame(base + len, p2, 60, "b2b2");
        check("b2b_gap", cap_c[base+len] - cap_c[base+len-1], 13);

        // Underrun after 20 payload bytes, next frame requested immediately.
        base = cap_d.size();
        u0 = und_n;
        p = {};
        for (int i = 0; i < 64; i++) p.push_back(8'(i + 100));
        drive(p, 20, 1'b0);
        @(posedge clk); #1;
        p2 = {};
        for (int i = 0; i < 60; i++) p2.push_back(8'(i * 3));
        drive(p2, 60, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        check("und_pulses", und_n - u0, 1);
        check("und_align", und_cyc, cap_c[base+27] + 1);
        check("und_first_data", cap_d[base+8], p[0]);
        check("und_last_data", cap_d[base+27], p[19]);
        check("und_gap", cap_c[base+28] - cap_c[base+27], 13);
        check("und_len", cap_d.size() - base, 28 + flen(60, 60));
        chk_frame(base + 28, p2, 60, "und_next");

        // Asynchronous reset in the middle of a frame.
        s_tvalid = 1'b1; s_tdata = 8'h77; s_tlast = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        check("mid_pre_tvalid", b_tvalid, 1);
        check("mid_pre_tready", b_tready, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", b_tvalid, 0);
        check("mid_rst_tdata",  b_tdata,  0);
        check("mid_rst_tready", b_tready, 0);
        s_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base = cap_d.size();
        repeat (20) @(posedge clk);
        #1;
        check("mid_rst_silent", cap_d.size() - base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
